// File: rtl/alu_issue_pkg.sv
// Decode constants, decoded-instruction record and the R-type decoder
// for the ALU issue unit.
package alu_issue_pkg;
`include "processor_defines.sv"

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SRL    = 3'b101;

  // Typed aliases of the shared macros so case items stay readable.
  localparam logic [4:0] ALU_ADD = `ALU_ADD;
  localparam logic [4:0] ALU_SUB = `ALU_SUB;
  localparam logic [4:0] ALU_XOR = `ALU_XOR;
  localparam logic [4:0] ALU_OR  = `ALU_OR;
  localparam logic [4:0] ALU_AND = `ALU_AND;
  localparam logic [4:0] ALU_SLL = `ALU_SLL;
  localparam logic [4:0] ALU_SRL = `ALU_SRL;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] ctrl;
    logic       illegal;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t d;
    d.rd      = instr[11:7];
    d.rs1     = instr[19:15];
    d.rs2     = instr[24:20];
    d.ctrl    = ALU_ADD;
    d.illegal = 1'b1;
    if (instr[6:0] == OPC_OP) begin
      d.illegal = 1'b0;
      case ({instr[31:25], instr[14:12]})
        {F7_BASE, F3_ADDSUB}: d.ctrl = ALU_ADD;
        {F7_ALT,  F3_ADDSUB}: d.ctrl = ALU_SUB;
        {F7_BASE, F3_XOR}:    d.ctrl = ALU_XOR;
        {F7_BASE, F3_OR}:     d.ctrl = ALU_OR;
        {F7_BASE, F3_AND}:    d.ctrl = ALU_AND;
        {F7_BASE, F3_SLL}:    d.ctrl = ALU_SLL;
        {F7_BASE, F3_SRL}:    d.ctrl = ALU_SRL;
        default:              d.illegal = 1'b1;
      endcase
    end
    return d;
  endfunction
endpackage

// File: rtl/alu_issue_if.sv
// Instruction, alu_core, result and debug channels of the ALU issue unit.
interface alu_issue_if #(parameter int XLEN = 32);
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] alu_rs1_val;
  logic [XLEN-1:0] alu_rs2_val;
  logic [4:0]      alu_control;
  logic [XLEN-1:0] alu_rd_write_val;
  logic            res_valid;
  logic            res_ready;
  logic [4:0]      res_rd;
  logic [XLEN-1:0] res_val;
  logic            res_illegal;
  logic [4:0]      dbg_addr;
  logic [XLEN-1:0] dbg_val;

  modport master (
    input  instr_valid, instr, alu_rd_write_val, res_ready, dbg_addr,
    output instr_ready, alu_rs1_val, alu_rs2_val, alu_control,
           res_valid, res_rd, res_val, res_illegal, dbg_val
  );

  modport slave (
    output instr_valid, instr, alu_rd_write_val, res_ready, dbg_addr,
    input  instr_ready, alu_rs1_val, alu_rs2_val, alu_control,
           res_valid, res_rd, res_val, res_illegal, dbg_val
  );
endinterface

// File: rtl/alu_issue_regfile.sv
// Register file: two combinational read ports, a debug read, one
// synchronous write port; x0 always reads and stays zero.
module alu_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   ra1,
  output logic [XLEN-1:0] rd1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd2,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_val
);
  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;

  always_comb begin
    regs_d = regs_q;
    if (we && waddr != '0) regs_d[waddr] = wdata;
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) regs_q <= '0;
    else     regs_q <= regs_d;
  end

  assign rd1     = (ra1 == '0)      ? '0 : regs_q[ra1];
  assign rd2     = (ra2 == '0)      ? '0 : regs_q[ra2];
  assign dbg_val = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];
endmodule

// File: rtl/processor_defines.sv
// ALU operation encodings shared by alu_core and its initiators.
`ifndef PROCESSOR_DEFINES_SV
`define PROCESSOR_DEFINES_SV
`define ALU_ADD 5'b00000
`define ALU_SUB 5'b01000
`define ALU_XOR 5'b00100
`define ALU_OR  5'b00110
`define ALU_AND 5'b00111
`define ALU_SLL 5'b00001
`define ALU_SRL 5'b00101
`endif

// File: rtl/alu_issue_unit.sv
// Two-stage (EX, RES) issue unit: decodes R-type words, feeds an external
// alu_core from EX, writes back on EX->RES and reports retired records.
module alu_issue_unit
  import alu_issue_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input logic         clk,
  input logic         rst,
  alu_issue_if.master bus
);
  dec_t            dec, ex_q, ex_d;
  logic            ex_valid_q, ex_valid_d;
  logic [XLEN-1:0] ex_a_q, ex_a_d, ex_b_q, ex_b_d;
  logic            res_valid_q, res_valid_d;
  logic [4:0]      res_rd_q, res_rd_d;
  logic [XLEN-1:0] res_val_q, res_val_d;
  logic            res_ill_q, res_ill_d;

  logic            ex_adv, instr_ready, accept, ex_live, ex_wb;
  logic [XLEN-1:0] rf_rd1, rf_rd2;

  alu_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .we       (ex_wb),
    .waddr    (ex_q.rd),
    .wdata    (bus.alu_rd_write_val),
    .ra1      (dec.rs1),
    .rd1      (rf_rd1),
    .ra2      (dec.rs2),
    .rd2      (rf_rd2),
    .dbg_addr (bus.dbg_addr),
    .dbg_val  (bus.dbg_val)
  );

  always_comb begin
    dec         = decode(bus.instr);
    ex_adv      = ex_valid_q && (!res_valid_q || bus.res_ready);
    instr_ready = !ex_valid_q || ex_adv;
    accept      = bus.instr_valid && instr_ready;
    ex_live     = ex_valid_q && !ex_q.illegal;
    // A retiring legal EX result is both the RF write and the bypass source.
    ex_wb       = ex_adv && !ex_q.illegal && (ex_q.rd != 5'd0);

    ex_valid_d = ex_valid_q;
    ex_d       = ex_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    if (ex_adv) ex_valid_d = 1'b0;
    if (accept) begin
      ex_valid_d = 1'b1;
      ex_d       = dec;
      ex_a_d     = (ex_wb && ex_q.rd == dec.rs1) ? bus.alu_rd_write_val : rf_rd1;
      ex_b_d     = (ex_wb && ex_q.rd == dec.rs2) ? bus.alu_rd_write_val : rf_rd2;
      if (dec.illegal) begin
        ex_a_d = '0;
        ex_b_d = '0;
      end
    end

    res_valid_d = res_valid_q;
    res_rd_d    = res_rd_q;
    res_val_d   = res_val_q;
    res_ill_d   = res_ill_q;
    if (res_valid_q && bus.res_ready) res_valid_d = 1'b0;
    if (ex_adv) begin
      res_valid_d = 1'b1;
      res_rd_d    = ex_q.rd;
      res_val_d   = ex_q.illegal ? '0 : bus.alu_rd_write_val;
      res_ill_d   = ex_q.illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_q        <= '0;
      ex_a_q      <= '0;
      ex_b_q      <= '0;
      res_valid_q <= 1'b0;
      res_rd_q    <= '0;
      res_val_q   <= '0;
      res_ill_q   <= 1'b0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_q        <= ex_d;
      ex_a_q      <= ex_a_d;
      ex_b_q      <= ex_b_d;
      res_valid_q <= res_valid_d;
      res_rd_q    <= res_rd_d;
      res_val_q   <= res_val_d;
      res_ill_q   <= res_ill_d;
    end
  end

  assign bus.instr_ready = instr_ready;
  assign bus.alu_control = ex_live ? ex_q.ctrl : ALU_ADD;
  assign bus.alu_rs1_val = ex_live ? ex_a_q : '0;
  assign bus.alu_rs2_val = ex_live ? ex_b_q : '0;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_rd      = res_rd_q;
  assign bus.res_val     = res_val_q;
  assign bus.res_illegal = res_ill_q;
endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural alu_core and an
// in-order scoreboard of expected retirement records.
module tb_alu_issue_unit;
  import alu_issue_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic seed_en;
  always #5 clk = ~clk;

  alu_issue_if #(.XLEN(32)) bus();

  alu_issue_unit #(.XLEN(32), .NREGS(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stand-in for alu_core; seed_en injects a constant 1 to bootstrap values.
  always_comb begin
    case (bus.alu_control)
      ALU_SUB: bus.alu_rd_write_val = bus.alu_rs1_val - bus.alu_rs2_val;
      ALU_XOR: bus.alu_rd_write_val = bus.alu_rs1_val ^ bus.alu_rs2_val;
      ALU_OR:  bus.alu_rd_write_val = bus.alu_rs1_val | bus.alu_rs2_val;
      ALU_AND: bus.alu_rd_write_val = bus.alu_rs1_val & bus.alu_rs2_val;
      ALU_SLL: bus.alu_rd_write_val = bus.alu_rs1_val << bus.alu_rs2_val[4:0];
      ALU_SRL: bus.alu_rd_write_val = bus.alu_rs1_val >> bus.alu_rs2_val[4:0];
      default: bus.alu_rd_write_val = bus.alu_rs1_val + bus.alu_rs2_val;
    endcase
    if (seed_en) bus.alu_rd_write_val = 32'd1;
  end

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
    logic        ill;
  } exp_t;
  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction

  function automatic logic [31:0] add_i(input logic [4:0] rd, rs1, rs2);
    return rtype(F7_BASE, rs2, rs1, F3_ADDSUB, rd);
  endfunction

  // Record monitor: every consumed record must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.res_valid && bus.res_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected record rd", {27'd0, bus.res_rd}, 32'hffff_ffff);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("record rd", {27'd0, bus.res_rd}, {27'd0, e.rd});
        chk("record val", bus.res_val, e.val);
        chk("record illegal", {31'd0, bus.res_illegal}, {31'd0, e.ill});
      end
    end
  end

  task automatic push(input logic [4:0] rd, input logic [31:0] v, input logic il);
    exp_t e;
    e.rd = rd; e.val = v; e.ill = il;
    sb.push_back(e);
  endtask

  // Offers a word, waits (bounded) for acceptance; leaves instr_valid high.
  task automatic issue(input logic [31:0] w, input logic [4:0] rd, input logic [31:0] v,
                       input logic il, output int waits);
    bus.instr_valid = 1'b1;
    bus.instr = w;
    waits = 0;
    @(negedge clk);
    while (!bus.instr_ready && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (!bus.instr_ready) begin
      chk("accept timeout", 32'd0, 32'd1);
      bus.instr_valid = 1'b0;
    end else begin
      push(rd, v, il);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bus.instr_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic dbg_chk(input logic [4:0] a, input logic [31:0] exp, input string tag);
    bus.dbg_addr = a;
    @(negedge clk);
    chk(tag, bus.dbg_val, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    int w;
    rst = 1'b1;
    seed_en = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr = 32'd0;
    bus.res_ready = 1'b1;
    bus.dbg_addr = 5'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("reset instr_ready", {31'd0, bus.instr_ready}, 32'd1);
    chk("reset res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("reset res_rd", {27'd0, bus.res_rd}, 32'd0);
    chk("reset res_val", bus.res_val, 32'd0);
    chk("reset res_illegal", {31'd0, bus.res_illegal}, 32'd0);
    @(posedge clk); #1;
    for (int a = 0; a < 32; a++) dbg_chk(a[4:0], 32'd0, "reset dbg sweep");

    // Seed x10=1, then build x1=5, x2=3 from ADDs
    seed_en = 1'b1;
    issue(add_i(5'd10, 5'd0, 5'd0), 5'd10, 32'd1, 1'b0, w);
    idle(2);
    seed_en = 1'b0;
    issue(add_i(5'd11, 5'd10, 5'd10), 5'd11, 32'd2, 1'b0, w);
    issue(add_i(5'd12, 5'd11, 5'd11), 5'd12, 32'd4, 1'b0, w);
    issue(add_i(5'd1, 5'd12, 5'd10), 5'd1, 32'd5, 1'b0, w);
    issue(add_i(5'd2, 5'd11, 5'd10), 5'd2, 32'd3, 1'b0, w);

    // Main operation mix
    issue(add_i(5'd3, 5'd1, 5'd2), 5'd3, 32'd8, 1'b0, w);
    issue(rtype(F7_ALT, 5'd2, 5'd1, F3_ADDSUB, 5'd4), 5'd4, 32'd2, 1'b0, w);
    issue(rtype(F7_BASE, 5'd2, 5'd1, F3_XOR, 5'd5), 5'd5, 32'd6, 1'b0, w);
    issue(rtype(F7_BASE, 5'd2, 5'd1, F3_SLL, 5'd6), 5'd6, 32'd40, 1'b0, w);
    issue(rtype(F7_BASE, 5'd2, 5'd6, F3_SRL, 5'd7), 5'd7, 32'd5, 1'b0, w);
    issue(rtype(F7_BASE, 5'd2, 5'd1, F3_OR, 5'd17), 5'd17, 32'd7, 1'b0, w);
    issue(rtype(F7_BASE, 5'd2, 5'd1, F3_AND, 5'd18), 5'd18, 32'd1, 1'b0, w);
    idle(2);
    dbg_chk(5'd6, 32'd40, "dbg x6");
    dbg_chk(5'd7, 32'd5, "dbg x7");

    // Back-to-back dependency through the bypass
    issue(add_i(5'd8, 5'd1, 5'd2), 5'd8, 32'd8, 1'b0, w);
    chk("b2b first no stall", w, 32'd0);
    issue(add_i(5'd9, 5'd8, 5'd8), 5'd9, 32'd16, 1'b0, w);
    chk("b2b second no stall", w, 32'd0);
    idle(2);
    dbg_chk(5'd9, 32'd16, "dbg x9");

    // Backpressure: two accepted, third held while RES stalls
    bus.res_ready = 1'b0;
    bus.instr_valid = 1'b1;
    bus.instr = add_i(5'd13, 5'd1, 5'd1);
    @(negedge clk);
    chk("bp accept A", {31'd0, bus.instr_ready}, 32'd1);
    push(5'd13, 32'd10, 1'b0);
    @(posedge clk); #1;
    bus.instr = add_i(5'd14, 5'd2, 5'd2);
    @(negedge clk);
    chk("bp accept B", {31'd0, bus.instr_ready}, 32'd1);
    push(5'd14, 32'd6, 1'b0);
    @(posedge clk); #1;
    bus.instr = rtype(F7_BASE, 5'd1, 5'd1, F3_XOR, 5'd15);
    repeat (4) begin
      @(negedge clk);
      chk("bp instr_ready low", {31'd0, bus.instr_ready}, 32'd0);
      chk("bp res_valid held", {31'd0, bus.res_valid}, 32'd1);
      chk("bp res_rd held", {27'd0, bus.res_rd}, 32'd13);
      chk("bp res_val held", bus.res_val, 32'd10);
      chk("bp res_illegal held", {31'd0, bus.res_illegal}, 32'd0);
      @(posedge clk); #1;
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("bp release accept C", {31'd0, bus.instr_ready}, 32'd1);
    push(5'd15, 32'd0, 1'b0);
    @(posedge clk); #1;
    idle(3);
    chk("bp drained", sb.size(), 32'd0);

    // Illegal words are consumed without stalling or writing the RF
    issue(32'h0000_0013, 5'd0, 32'd0, 1'b1, w);
    chk("illegal addi no stall", w, 32'd0);
    issue(rtype(7'b0000001, 5'd2, 5'd1, F3_ADDSUB, 5'd1), 5'd1, 32'd0, 1'b1, w);
    chk("illegal mul no stall", w, 32'd0);
    issue(add_i(5'd19, 5'd1, 5'd2), 5'd19, 32'd8, 1'b0, w);
    chk("after illegal no stall", w, 32'd0);
    idle(2);
    dbg_chk(5'd1, 32'd5, "dbg x1 after mul");

    // Write to x0
    issue(add_i(5'd0, 5'd1, 5'd2), 5'd0, 32'd8, 1'b0, w);
    idle(2);
    dbg_chk(5'd0, 32'd0, "dbg x0");

    // Reset with EX and RES both occupied
    bus.res_ready = 1'b0;
    issue(add_i(5'd20, 5'd1, 5'd2), 5'd20, 32'd8, 1'b0, w);
    issue(add_i(5'd21, 5'd1, 5'd1), 5'd21, 32'd10, 1'b0, w);
    bus.instr_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("midrst res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("midrst instr_ready", {31'd0, bus.instr_ready}, 32'd1);
    chk("midrst res_rd", {27'd0, bus.res_rd}, 32'd0);
    @(posedge clk); #1;
    dbg_chk(5'd21, 32'd0, "midrst dbg x21");
    dbg_chk(5'd1, 32'd0, "midrst dbg x1");
    bus.res_ready = 1'b1;
    issue(add_i(5'd3, 5'd1, 5'd2), 5'd3, 32'd0, 1'b0, w);
    idle(1);

    begin
      int n = 0;
      while (sb.size() != 0 && n < 20) begin @(posedge clk); n++; end
    end
    #1;
    chk("final drain", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
